op_engine: RTL

Parametrised successor of the single-shot 8-bit operation unit. It sits between the server (level `op_start` / toggle acknowledge handshake) and the output FIFO. It captures one operand per request, applies one of eight bit-manipulation operations of configurable width, and writes the result into the FIFO. It honours FIFO backpressure and never drops or duplicates a result.

---
 rtl/op_engine.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/op_engine.sv
// op_engine: captures one operand per level request, applies one of eight
// bit-manipulation operations and writes the result into the output FIFO,
// honouring backpressure. Optional statistics counters are built when the
// macro OP_ENGINE_STATS_EN is defined (ports op_count, stall_count).
module op_engine #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SHIFT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] data_in,
    input  logic              op_start,
    input  logic              fifo_full,
    output logic              ack_toggle,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy
`ifdef OP_ENGINE_STATS_EN
    ,
    output logic [15:0]       op_count,
    output logic [15:0]       stall_count
`endif
);

    localparam int unsigned HALF_W = DATA_W / 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_HOLD     = 2'd2,
        ST_WAIT_LOW = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   operand_q, operand_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   result_c;
    logic                write_c;

    // Combinational datapath: one of eight operations on the captured operand.
    function automatic logic [DATA_W-1:0] apply_op(input logic [2:0] op,
                                                   input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] rev;
        logic [DATA_W-1:0] r;
        rev = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            rev[i] = x[int'(DATA_W) - 1 - i];
        end
        case (op)
            3'd0:    r = x;
            3'd1:    r = x << SHIFT;
            3'd2:    r = (x >> SHIFT) | (x << (DATA_W - SHIFT));
            3'd3:    r = ~x;
            3'd4:    r = (x << SHIFT) | (x >> (DATA_W - SHIFT));
            3'd5:    r = x >> SHIFT;
            3'd6:    r = {x[HALF_W-1:0], x[DATA_W-1:HALF_W]};
            default: r = rev;
        endcase
        return r;
    endfunction

    assign result_c = apply_op(op_q, operand_q);

    // Next-state and output logic; a write happens from EXEC or HOLD when the FIFO has room.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        operand_d    = operand_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        ack_d        = ack_q;
        write_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    op_d      = op_code;
                    operand_d = data_in;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!fifo_full) begin
                    write_c = 1'b1;
                    state_d = ST_WAIT_LOW;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!fifo_full) begin
                    write_c = 1'b1;
                    state_d = ST_WAIT_LOW;
                end
            end
            default: begin
                if (!op_start) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        if (write_c) begin
            data_out_d   = result_c;
            data_valid_d = 1'b1;
            ack_d        = ~ack_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, captured operands and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= 3'd0;
            operand_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            operand_q    <= operand_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
        end
    end

    assign ack_toggle = ack_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;

`ifdef OP_ENGINE_STATS_EN
    logic [15:0] op_count_q, op_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    // Write counter wraps; stall counter saturates and counts cycles spent in HOLD.
    always_comb begin
        op_count_d    = op_count_q;
        stall_count_d = stall_count_q;
        if (write_c) begin
            op_count_d = op_count_q + 16'd1;
        end
        if ((state_q == ST_HOLD) && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q    <= 16'd0;
            stall_count_q <= 16'd0;
        end else begin
            op_count_q    <= op_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign op_count    = op_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
